// File: rtl/qpsk_tx_pkg.sv
// rtl/qpsk_tx_pkg.sv - shared types and helpers for the QPSK TX repeater slice
package qpsk_tx_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b01,
        SEND  = 2'b10
    } rep_state_t;

    // Zero repeats make no sense on the wire, so the count is forced into 1..max_rep.
    function automatic int clamp_rep(input int rep_cnt, input int max_rep);
        if (rep_cnt < 1) begin
            return 1;
        end else if (rep_cnt > max_rep) begin
            return max_rep;
        end
        return rep_cnt;
    endfunction

endpackage

// File: rtl/axis_repeater_v2_if.sv
// rtl/axis_repeater_v2_if.sv - AXI-Stream bundle used on both sides of the repeater
interface axis_repeater_v2_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_repeater_v2_slot.sv
// rtl/axis_repeater_v2_slot.sv - one word of storage (valid/data/last/repeat count)
module axis_word_slot #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_last,
    input  logic [CNT_W-1:0]  d_r,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic [CNT_W-1:0]  r
);

    // load wins over clear so a slot can be emptied and refilled in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
            r     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            last  <= d_last;
            r     <= d_r;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_repeater_v2.sv
// rtl/axis_repeater_v2.sv - AXI-Stream sample repeater with per-word run-time count
// Optional REPEATER_ZERO_STUFF_EN: repeats 1..R-1 carry zero data instead of the sample.
module axis_repeater_v2
    import qpsk_tx_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MAX_REP = 16,
    parameter int CNT_W   = $clog2(MAX_REP + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CNT_W-1:0]     rep_cnt,
    axis_repeater_v2_if.slave    axis_in,
    axis_repeater_v2_if.master   axis_out,
    output logic [CNT_W-1:0]     rep_idx
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    rep_state_t state_q, state_d;
    logic [CNT_W-1:0] idx_d;
    logic [CNT_W-1:0] in_r;
    logic in_ready_q, in_hs, out_hs, last_beat;

    logic              cur_valid, cur_last;
    logic [DATA_W-1:0] cur_data;
    logic [CNT_W-1:0]  cur_r;
    logic              pend_valid, pend_last;
    logic [DATA_W-1:0] pend_data;
    logic [CNT_W-1:0]  pend_r;

    logic cur_load, cur_clear, cur_from_pend, pend_load, pend_clear;
    logic [DATA_W-1:0] cur_d_data;
    logic              cur_d_last;
    logic [CNT_W-1:0]  cur_d_r;

    assign in_r      = CNT_W'(clamp_rep(int'(rep_cnt), MAX_REP));
    assign in_hs     = axis_in.tvalid & in_ready_q;
    assign out_hs    = cur_valid & axis_out.tready;
    assign last_beat = (rep_idx == cur_r - ONE);

    assign cur_d_data = cur_from_pend ? pend_data : axis_in.tdata;
    assign cur_d_last = cur_from_pend ? pend_last : axis_in.tlast;
    assign cur_d_r    = cur_from_pend ? pend_r    : in_r;

    axis_word_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_cur (
        .clk(clk), .reset_n(reset_n), .load(cur_load), .clear(cur_clear),
        .d_data(cur_d_data), .d_last(cur_d_last), .d_r(cur_d_r),
        .valid(cur_valid), .data(cur_data), .last(cur_last), .r(cur_r)
    );

    axis_word_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_pend (
        .clk(clk), .reset_n(reset_n), .load(pend_load), .clear(pend_clear),
        .d_data(axis_in.tdata), .d_last(axis_in.tlast), .d_r(in_r),
        .valid(pend_valid), .data(pend_data), .last(pend_last), .r(pend_r)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            rep_idx    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rep_idx    <= idx_d;
            in_ready_q <= !(pend_load | (pend_valid & !pend_clear));
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = rep_idx;
        cur_load      = 1'b0;
        cur_clear     = 1'b0;
        cur_from_pend = 1'b0;
        pend_load     = 1'b0;
        pend_clear    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    cur_load = 1'b1;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (out_hs && last_beat) begin
                    idx_d = '0;
                    if (pend_valid) begin
                        cur_load      = 1'b1;
                        cur_from_pend = 1'b1;
                        pend_clear    = 1'b1;
                        pend_load     = in_hs;
                    end else if (in_hs) begin
                        cur_load = 1'b1;
                    end else begin
                        cur_clear = 1'b1;
                        state_d   = EMPTY;
                    end
                end else begin
                    if (out_hs) begin
                        idx_d = rep_idx + ONE;
                    end
                    pend_load = in_hs;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign axis_in.tready  = in_ready_q;
    assign axis_out.tvalid = cur_valid;
    assign axis_out.tlast  = cur_last & last_beat;
`ifdef REPEATER_ZERO_STUFF_EN
    assign axis_out.tdata  = (rep_idx == '0) ? cur_data : '0;
`else
    assign axis_out.tdata  = cur_data;
`endif

endmodule
